// File: rtl/active_block_fifo.sv
// active_block_fifo: block-transfer endpoint on the uc_in/uc_out bus with
// independent RX (host-to-device) and TX (device-to-host) byte FIFOs.
module active_block_fifo #(
  parameter logic [2:0]  ADDR       = 3'd0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned CMD_HOLD   = 2
) (
  input  logic        uc_clk,
  input  logic        uc_reset,
  input  logic [31:0] uc_in,
  output logic [29:0] uc_out,
  input  logic        tx_wr_en,
  input  logic [7:0]  tx_data,
  output logic        tx_full,
  output logic [AW:0] tx_level,
  input  logic        tx_start,
  input  logic [7:0]  tx_len,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err,
  input  logic        rx_rd_en,
  output logic [7:0]  rx_data,
  output logic        rx_empty,
  output logic [AW:0] rx_level,
  output logic [7:0]  rx_len,
  output logic        rx_block_done,
  output logic        rx_overflow
);

  localparam logic [AW:0] DEPTH_V   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_INC   = (AW+1)'(1);
  localparam logic [7:0]  HOLD_LAST = 8'(CMD_HOLD - 1);

  typedef enum logic [3:0] {
    R_IDLE = 4'b0001,
    R_CMD  = 4'b0010,
    R_BYTE = 4'b0100,
    R_WAIT = 4'b1000
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_CMD,
    T_XFER,
    T_END
  } tx_state_e;

  // Strobe edge detection: one byte per rising edge regardless of width.
  logic uc_in30_q;
  logic stb_rise;

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) uc_in30_q <= 1'b0;
    else          uc_in30_q <= uc_in[30];
  end

  assign stb_rise = uc_in[30] & ~uc_in30_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^uc_in[17:8];

  // TX FIFO
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr_q, tx_rptr_q;
  logic tx_empty, tx_push, tx_pop;

  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign tx_full  = (tx_level == DEPTH_V);
  assign tx_empty = (tx_level == '0);
  assign tx_push  = tx_wr_en & ~tx_full;

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_INC;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_INC;
    end
  end

  always_ff @(posedge uc_clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_data;
  end

  // RX FIFO
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wptr_q, rx_rptr_q;
  logic rx_full, rx_push_req, rx_push, rx_pop;

  assign rx_level = rx_wptr_q - rx_rptr_q;
  assign rx_full  = (rx_level == DEPTH_V);
  assign rx_empty = (rx_level == '0);
  assign rx_push  = rx_push_req & ~rx_full;
  assign rx_pop   = rx_rd_en & ~rx_empty;
  assign rx_data  = rx_mem[rx_rptr_q[AW-1:0]];

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_INC;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_INC;
    end
  end

  always_ff @(posedge uc_clk) begin
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= uc_in[7:0];
  end

  // RX FSM
  rx_state_e rx_state_q;
  logic [7:0] rcnt_q, rx_len_q;
  logic rx_done_q, rx_ovf_q;
  logic addr_hit;

  assign addr_hit    = (uc_in[29:27] == ADDR);
  assign rx_push_req = (rx_state_q == R_BYTE) & stb_rise;

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      rx_state_q <= R_IDLE;
      rcnt_q     <= '0;
      rx_len_q   <= '0;
      rx_done_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      // Dropped bytes still advance rcnt so the block ends on time.
      if (rx_push_req && rx_full) rx_ovf_q <= 1'b1;
      case (rx_state_q)
        R_IDLE: if (addr_hit && uc_in[26]) rx_state_q <= R_CMD;
        R_CMD: begin
          rx_len_q <= uc_in[25:18];
          rcnt_q   <= '0;
          if (uc_in[25:18] == 8'd0) begin
            rx_done_q  <= 1'b1;
            rx_state_q <= R_WAIT;
          end else begin
            rx_state_q <= R_BYTE;
          end
        end
        R_BYTE: begin
          if (stb_rise) begin
            rcnt_q <= rcnt_q + 8'd1;
            if (rcnt_q + 8'd1 == rx_len_q) begin
              rx_done_q  <= 1'b1;
              rx_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT:  if (!uc_in[26]) rx_state_q <= R_IDLE;
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  assign rx_len        = rx_len_q;
  assign rx_block_done = rx_done_q;
  assign rx_overflow   = rx_ovf_q;

  // TX FSM; uc_out is written with the value for the state being entered.
  tx_state_e tx_state_q;
  logic [7:0] tcnt_q, hcnt_q;
  logic [29:0] uc_out_q;
  logic tx_busy_q, tx_done_q, tx_err_q;
  logic tx_accept;

  assign tx_accept = ~uc_in[31] & (tx_len != 8'd0) & (9'(tx_level) >= {1'b0, tx_len});
  assign tx_pop    = (tx_state_q == T_XFER) & stb_rise & (tcnt_q != 8'd0) & ~tx_empty;

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      tx_state_q <= T_IDLE;
      tcnt_q     <= '0;
      hcnt_q     <= '0;
      uc_out_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (tx_state_q)
        T_IDLE: begin
          if (tx_start) begin
            if (tx_accept) begin
              tx_state_q <= T_CMD;
              tcnt_q     <= tx_len;
              hcnt_q     <= '0;
              uc_out_q   <= {ADDR, 1'b1, tx_len, 9'd0, 1'b0, 8'd0};
              tx_busy_q  <= 1'b1;
            end else begin
              tx_err_q <= 1'b1;
            end
          end
        end
        T_CMD: begin
          if (hcnt_q == HOLD_LAST) begin
            tx_state_q  <= T_XFER;
            uc_out_q[8] <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        T_XFER: begin
          // Checked a cycle after the final pop so the last byte is visible.
          if (tcnt_q == 8'd0) begin
            tx_state_q <= T_END;
            uc_out_q   <= '0;
            tx_done_q  <= 1'b1;
          end else if (tx_pop) begin
            uc_out_q[7:0] <= tx_mem[tx_rptr_q[AW-1:0]];
            tcnt_q        <= tcnt_q - 8'd1;
          end
        end
        T_END: begin
          tx_state_q <= T_IDLE;
          tx_busy_q  <= 1'b0;
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  assign uc_out  = uc_out_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;
  assign tx_err  = tx_err_q;

endmodule
